// File: rtl/lcd_pkg.sv
// Shared LCD definitions: fetch scheduler state encoding, default panel
// geometry (also used by the LCD timing generator) and a counter-width helper.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_REQ   = 3'd2,
    ST_BURST = 3'd3,
    ST_DONE  = 3'd4
  } lcd_state_e;

  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_V_ACTIVE = 480;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_pix_cnt.sv
// Pixel position counter: x runs 0..H_ACTIVE-1 and wraps into the next line,
// y runs 0..V_ACTIVE-1 and wraps at the end of the frame. last_pix_o flags
// the final pixel of the frame at the current position.
module lcd_pix_cnt
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int X_W      = cnt_w(H_ACTIVE),
  parameter int Y_W      = cnt_w(V_ACTIVE)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           inc_i,
  output logic [X_W-1:0] x_o,
  output logic           last_pix_o
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // Next position: clear wins, otherwise advance with line and frame wrap.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_q + Y_W'(1);
        end
      end else begin
        x_d = x_q + X_W'(1);
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o        = x_q;
  assign last_pix_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/lcd_fetch_sched.sv
// Frame-fetch scheduler for the LCD line FIFO write side. Starts a frame on
// lcd_framesync, requests line-bounded bursts only when the FIFO has room for
// a full burst, gates source beats into the FIFO and stops after one frame.
module lcd_fetch_sched
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE              = LCD_H_ACTIVE,
  parameter int V_ACTIVE              = LCD_V_ACTIVE,
  parameter int BURST_LEN             = 64,
  parameter int FIFO_ALMOSTFULL_DEPTH = 1000,
  parameter int FIFO_CNT_W            = 11
) (
  input  logic                  fifo_wr_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  lcd_framesync,
  output logic                  axis_data_sync,
  output logic                  axis_data_requst,
  input  logic                  axis_data_en,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  input  logic [FIFO_CNT_W-1:0] fifo_wr_cnt,
  output logic                  frame_busy,
  output logic                  drop_err,
  output logic                  abort_err
);

  localparam int X_W  = cnt_w(H_ACTIVE);
  localparam int Y_W  = cnt_w(V_ACTIVE);
  localparam int BC_W = cnt_w(BURST_LEN + 1);

  // FIFO headroom check is done one bit wider than the level so it cannot wrap.
  localparam logic [FIFO_CNT_W:0] LVL_BURST = (FIFO_CNT_W + 1)'(BURST_LEN);
  localparam logic [FIFO_CNT_W:0] LVL_CEIL  = (FIFO_CNT_W + 1)'(FIFO_ALMOSTFULL_DEPTH);
  localparam logic [X_W:0]        H_EXT     = (X_W + 1)'(H_ACTIVE);
  localparam logic [X_W:0]        BL_EXT    = (X_W + 1)'(BURST_LEN);

  lcd_state_e      state_q, state_d;
  logic [BC_W-1:0] blen_q, blen_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic            sync_q, req_q, busy_q, drop_q, abort_q;

  logic [X_W-1:0]        x_s;
  logic                  last_pix_s;
  logic                  cnt_clr_s;
  logic                  wr_en_s;
  logic                  abort_s;
  logic                  room_s;
  logic [FIFO_CNT_W:0]   lvl_sum_s;
  logic [X_W:0]          rem_s;
  logic [BC_W-1:0]       blen_s;
  logic [BC_W-1:0]       bcnt_inc_s;

  lcd_pix_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_pix_cnt (
    .clk_i      (fifo_wr_clk),
    .rst_i      (rst),
    .clr_i      (cnt_clr_s),
    .inc_i      (wr_en_s),
    .x_o        (x_s),
    .last_pix_o (last_pix_s)
  );

  // Beat gating, FIFO headroom and the line-bounded length of the next burst.
  always_comb begin
    wr_en_s    = axis_data_en & (state_q == ST_BURST) & ~fifo_full;
    lvl_sum_s  = {1'b0, fifo_wr_cnt} + LVL_BURST;
    room_s     = (lvl_sum_s <= LVL_CEIL);
    rem_s      = H_EXT - {1'b0, x_s};
    bcnt_inc_s = bcnt_q + BC_W'(1);
    if (rem_s < BL_EXT) begin
      blen_s = BC_W'(rem_s);
    end else begin
      blen_s = BC_W'(BURST_LEN);
    end
  end

  // Next-state logic; enable low forces IDLE from any state without error.
  always_comb begin
    state_d   = state_q;
    blen_d    = blen_q;
    bcnt_d    = bcnt_q;
    cnt_clr_s = 1'b0;
    abort_s   = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lcd_framesync) begin
            state_d = ST_SYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SYNC: begin
          cnt_clr_s = 1'b1;
          state_d   = ST_REQ;
        end
        ST_REQ: begin
          if (lcd_framesync) begin
            abort_s = 1'b1;
            state_d = ST_SYNC;
          end else if (room_s) begin
            blen_d  = blen_s;
            bcnt_d  = '0;
            state_d = ST_BURST;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_BURST: begin
          if (lcd_framesync) begin
            abort_s = 1'b1;
            state_d = ST_SYNC;
          end else if (wr_en_s) begin
            bcnt_d = bcnt_inc_s;
            if (bcnt_inc_s == blen_q) begin
              state_d = last_pix_s ? ST_DONE : ST_REQ;
            end else begin
              state_d = ST_BURST;
            end
          end else begin
            state_d = ST_BURST;
          end
        end
        ST_DONE: begin
          if (lcd_framesync) begin
            state_d = ST_SYNC;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and burst bookkeeping registers.
  always_ff @(posedge fifo_wr_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blen_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      blen_q  <= blen_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Registered status outputs decoded from the next state, plus sticky errors.
  always_ff @(posedge fifo_wr_clk) begin
    if (rst) begin
      sync_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      sync_q  <= (state_d == ST_SYNC);
      req_q   <= (state_d == ST_BURST);
      busy_q  <= (state_d == ST_SYNC) || (state_d == ST_REQ) || (state_d == ST_BURST);
      drop_q  <= drop_q | (axis_data_en & ~wr_en_s);
      abort_q <= abort_q | abort_s;
    end
  end

  assign axis_data_sync   = sync_q;
  assign axis_data_requst = req_q;
  assign frame_busy       = busy_q;
  assign drop_err         = drop_q;
  assign abort_err        = abort_q;
  assign fifo_wr_en       = wr_en_s;

endmodule

// File: tb/tb_lcd_fetch_sched.sv
// Directed bench for lcd_fetch_sched with an 8x2 frame and 3-beat bursts.
module tb_lcd_fetch_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        lcd_framesync = 1'b0;
  logic        axis_data_sync;
  logic        axis_data_requst;
  logic        axis_data_en = 1'b0;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;
  logic [10:0] fifo_wr_cnt = 11'd0;
  logic        frame_busy;
  logic        drop_err;
  logic        abort_err;

  int total = 0;
  int bad   = 0;

  // Expected output vector order: {sync, requst, wr_en, busy, drop, abort}
  typedef struct {
    logic        r;
    logic        e;
    logic        fs;
    logic        ax;
    logic        full;
    logic [10:0] cnt;
    logic [5:0]  exp;
  } vec_t;

  vec_t vq[$];

  lcd_fetch_sched #(
    .H_ACTIVE              (8),
    .V_ACTIVE              (2),
    .BURST_LEN             (3),
    .FIFO_ALMOSTFULL_DEPTH (1000),
    .FIFO_CNT_W            (11)
  ) dut (
    .fifo_wr_clk      (clk),
    .rst              (rst),
    .enable           (enable),
    .lcd_framesync    (lcd_framesync),
    .axis_data_sync   (axis_data_sync),
    .axis_data_requst (axis_data_requst),
    .axis_data_en     (axis_data_en),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_wr_cnt      (fifo_wr_cnt),
    .frame_busy       (frame_busy),
    .drop_err         (drop_err),
    .abort_err        (abort_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, sample mid-cycle, advance.
  task automatic cyc(input string nm, input logic r, input logic e, input logic fs,
                     input logic ax, input logic full, input logic [10:0] cnt,
                     input logic [5:0] exp);
    rst = r; enable = e; lcd_framesync = fs; axis_data_en = ax;
    fifo_full = full; fifo_wr_cnt = cnt;
    #4;
    chk(nm, {26'd0, axis_data_sync, axis_data_requst, fifo_wr_en, frame_busy,
             drop_err, abort_err}, {26'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic add(input int n, input logic fs, input logic ax, input logic [5:0] exp);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.r = 1'b0; v.e = 1'b1; v.fs = fs; v.ax = ax; v.full = 1'b0;
      v.cnt = 11'd0; v.exp = exp;
      vq.push_back(v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; lcd_framesync = 1'b0; axis_data_en = 1'b0;
    fifo_full = 1'b0; fifo_wr_cnt = 11'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Source answers every request; count writes until the frame completes.
  task automatic drain(input string nm, input int exp_w);
    int  w = 0;
    bit  done = 1'b0;
    lcd_framesync = 1'b0; fifo_full = 1'b0; fifo_wr_cnt = 11'd0;
    for (int i = 0; i < 200; i++) begin
      axis_data_en = axis_data_requst;
      #4;
      if (fifo_wr_en === 1'b1) w++;
      if (frame_busy === 1'b0) done = 1'b1;
      @(posedge clk); #1;
      if (done) break;
    end
    axis_data_en = 1'b0;
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_writes"}, w, exp_w);
  endtask

  initial begin
    do_reset();

    // Nominal frame: bursts 3,3,2 per line, then a stray beat in DONE.
    add(1, 1'b1, 1'b0, 6'b000000);
    add(1, 1'b0, 1'b0, 6'b100100);
    for (int ln = 0; ln < 2; ln++) begin
      add(1, 1'b0, 1'b0, 6'b000100);
      add(3, 1'b0, 1'b1, 6'b011100);
      add(1, 1'b0, 1'b0, 6'b000100);
      add(3, 1'b0, 1'b1, 6'b011100);
      add(1, 1'b0, 1'b0, 6'b000100);
      add(2, 1'b0, 1'b1, 6'b011100);
    end
    add(1, 1'b0, 1'b1, 6'b000000);
    add(1, 1'b0, 1'b0, 6'b000010);
    for (int i = 0; i < vq.size(); i++) begin
      cyc($sformatf("nominal_row%0d", i), vq[i].r, vq[i].e, vq[i].fs, vq[i].ax,
          vq[i].full, vq[i].cnt, vq[i].exp);
    end

    // Stray beat in the cycle after a burst's last beat.
    do_reset();
    cyc("stray_idle",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("stray_sync",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b100100);
    cyc("stray_req",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000100);
    for (int i = 0; i < 3; i++)
      cyc("stray_burst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011100);
    cyc("stray_after",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b000100);
    cyc("stray_drop",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b010110);

    // FIFO headroom: 998+3 > 1000 holds REQ, 997+3 = 1000 starts the burst.
    do_reset();
    cyc("room_idle",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0,   6'b000000);
    cyc("room_sync",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0,   6'b100100);
    for (int i = 0; i < 3; i++)
      cyc("room_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd998, 6'b000100);
    cyc("room_pass",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd997, 6'b000100);
    cyc("room_burst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   6'b011100);

    // FIFO full for two beats mid-burst: dropped, frame still 16 writes.
    do_reset();
    cyc("full_idle",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("full_sync",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b100100);
    cyc("full_req",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000100);
    cyc("full_b1",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011100);
    cyc("full_f1",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd0, 6'b010100);
    cyc("full_f2",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd0, 6'b010110);
    cyc("full_b2",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011110);
    cyc("full_b3",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011110);
    cyc("full_req2",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000110);
    drain("full_rest", 13);
    cyc("full_done",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000010);

    // Frame sync after 5 accepted beats aborts and restarts a full frame.
    do_reset();
    cyc("abort_idle", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("abort_sync", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b100100);
    cyc("abort_req",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000100);
    for (int i = 0; i < 3; i++)
      cyc("abort_b",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011100);
    cyc("abort_req2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000100);
    for (int i = 0; i < 2; i++)
      cyc("abort_b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011100);
    cyc("abort_fs",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 6'b010100);
    cyc("abort_resync", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b100101);
    cyc("abort_req3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000101);
    drain("abort_frame", 16);
    cyc("abort_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000001);

    // Reset asserted mid-burst clears every output on the next edge.
    do_reset();
    cyc("rst_idle",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("rst_sync",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b100100);
    cyc("rst_req",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000100);
    cyc("rst_b1",     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011100);
    cyc("rst_assert", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011100);
    cyc("rst_after",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000000);

    // Enable dropped mid-burst: IDLE, no error; sync ignored while disabled.
    cyc("en_idle",    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("en_sync",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b100100);
    cyc("en_req",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000100);
    cyc("en_b1",      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 6'b011100);
    cyc("en_low",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 6'b010100);
    cyc("en_off",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("en_off_fs",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("en_on",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("en_fs",      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 6'b000000);
    cyc("en_resync",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b100100);
    drain("en_frame", 16);
    cyc("en_done",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
